count_sched: RTL and testbench
==============================

COUNT_SCHED -- requirements
Module: count_sched

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the counter (2..8).
REQ-002 Parameter CNT_W, default 4, counter and job-length width in bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous active-low reset; low forces reset state immediately, release takes effect at the next rising clk edge.
REQ-005 req  input  N_REQ  per-requester job request; level, held high until the job's done pulse.
REQ-006 len  input  N_REQ*CNT_W  per-requester job length; slice i is bits [i*CNT_W +: CNT_W].
REQ-007 gnt  output  N_REQ  one-hot grant to the owner of the shared counter; all-zero when idle.
REQ-008 done  output  N_REQ  one-cycle completion pulse to the job owner.
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 cnt  output  CNT_W  current shared counter value.

Function
REQ-011 States: IDLE, LOAD, COUNT, DONE; all outputs are registered or decoded from registered state only.
REQ-012 IDLE: if any req bit is high, the block selects winner w round-robin, searching upward from pointer ptr with wrap (N_REQ-1 -> 0), and moves to LOAD; otherwise it stays in IDLE.
REQ-013 LOAD: limit <= len slice w; cnt <= 0; next state COUNT; gnt[w] high from LOAD entry.
REQ-014 COUNT: if cnt == limit, next state is DONE; otherwise cnt <= cnt + 1 (CNT_W bits, no wrap possible since limit <= 2^CNT_W-1).
REQ-015 A job occupies LOAD(1) + COUNT(limit+1) + DONE(1) = limit+3 cycles; len=0 gives 3 cycles.
REQ-016 DONE: done[w] high for exactly this cycle; ptr <= (w+1) mod N_REQ; next state IDLE; gnt[w] stays high through DONE and drops on IDLE entry.
REQ-017 Back-to-back: at least one IDLE cycle separates consecutive jobs; rearbitration happens in that IDLE cycle.
REQ-018 len is sampled only in LOAD; later changes to len do not affect the running job.
REQ-019 Abort: if req[w] is low during LOAD or COUNT, next state is IDLE, no done pulse, ptr <= (w+1) mod N_REQ, and cnt holds its value.
REQ-020 Requests from non-owners during a job are ignored until the next IDLE cycle; they are not latched.
REQ-021 req[w] low in DONE has no effect; the done pulse still occurs.
REQ-022 Simultaneous requests: the lowest index at or above ptr wins, otherwise the lowest index overall after wrap.
REQ-023 gnt is always one-hot or zero, and done is always one-hot or zero with done ⊆ gnt.

Reset
REQ-024 While rst is low: state IDLE, ptr 0, limit 0, cnt 0, gnt 0, done 0, busy 0.
REQ-025 Reset mid-job discards the job with no done pulse; after release the block arbitrates from ptr 0.

Verification
REQ-026 Single job: req=0001, len[0]=5 -> gnt=0001 for 8 cycles; cnt steps 0..5; done[0] pulses in cycle 8; busy drops after.
REQ-027 Round-robin: req=1111 held, all len=0 -> grant order 0,1,2,3,0; each job lasts 3 cycles with 1 IDLE cycle between jobs.
REQ-028 Zero and max length: len[2]=0 -> 3-cycle job; len[2]=15 -> 18-cycle job, cnt reaches 15 with no wrap.
REQ-029 Abort: req[1] dropped when cnt=3 -> next state IDLE, no done, ptr=2; a pending req[2] is granted next.
REQ-030 Async reset: rst low mid-COUNT between clk edges -> gnt, busy and cnt go to 0 without a clock edge; after release, req=1000 is granted via search from ptr 0.
REQ-031 len change: len[0] changed 5->2 during COUNT -> the job still runs to cnt=5.

Source files
------------

// File: rtl/count_sched.sv
// Shared-counter scheduler: round-robin arbitration among N_REQ requesters,
// each owning the counter for one job of length len[i] (limit+3 cycles).
`timescale 1ns/1ps

module count_sched #(
   parameter int N_REQ = 4,
   parameter int CNT_W = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*CNT_W-1:0]   len,
   output logic [N_REQ-1:0]         gnt,
   output logic [N_REQ-1:0]         done,
   output logic                     busy,
   output logic [CNT_W-1:0]         cnt
);

   localparam int          PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned NR    = N_REQ;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      COUNT,
      DONE
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
   logic [PTR_W-1:0] r_owner, w_owner_nxt;
   logic [CNT_W-1:0] r_limit, w_limit_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

   logic [PTR_W-1:0] w_win;
   logic             w_any;
   logic [PTR_W-1:0] w_owner_inc;
   logic             w_req_own;
   logic [CNT_W-1:0] w_len_sel;
   logic [N_REQ-1:0] w_owner_oh;

   // Round-robin search: first requester at or above r_ptr, wrapping to 0.
   always_comb begin
      int unsigned      idx;
      logic [PTR_W-1:0] w_idx;
      w_win = '0;
      w_any = 1'b0;
      idx   = 0;
      w_idx = '0;
      for (int unsigned k = 0; k < NR; k++) begin
         idx   = (32'(r_ptr) + k) % NR;
         w_idx = PTR_W'(idx);
         if (!w_any && req[w_idx]) begin
            w_any = 1'b1;
            w_win = w_idx;
         end
      end
   end

   always_comb begin
      w_req_own  = 1'b0;
      w_len_sel  = '0;
      w_owner_oh = '0;
      for (int unsigned i = 0; i < NR; i++) begin
         if (r_owner == PTR_W'(i)) begin
            w_req_own     = req[i];
            w_len_sel     = len[i*CNT_W +: CNT_W];
            w_owner_oh[i] = 1'b1;
         end
      end
      w_owner_inc = (r_owner == PTR_W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_owner <= '0;
         r_limit <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_owner <= w_owner_nxt;
         r_limit <= w_limit_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // An owner dropping req in LOAD/COUNT aborts the job; the counter is left as-is.
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_owner_nxt = r_owner;
      w_limit_nxt = r_limit;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         IDLE: begin
            if (w_any) begin
               w_owner_nxt = w_win;
               w_state_nxt = LOAD;
            end
         end
         LOAD: begin
            if (!w_req_own) begin
               w_ptr_nxt   = w_owner_inc;
               w_state_nxt = IDLE;
            end else begin
               w_limit_nxt = w_len_sel;
               w_cnt_nxt   = '0;
               w_state_nxt = COUNT;
            end
         end
         COUNT: begin
            if (!w_req_own) begin
               w_ptr_nxt   = w_owner_inc;
               w_state_nxt = IDLE;
            end else if (r_cnt == r_limit) begin
               w_state_nxt = DONE;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         DONE: begin
            w_ptr_nxt   = w_owner_inc;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state != IDLE);
      gnt  = (r_state != IDLE) ? w_owner_oh : '0;
      done = (r_state == DONE) ? w_owner_oh : '0;
      cnt  = r_cnt;
   end

endmodule

// File: tb/tb_count_sched.sv
// Directed bench for count_sched (N_REQ=4, CNT_W=4) with hand-computed expectations.
`timescale 1ns/1ps

module tb_count_sched;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [15:0] len;
   logic [3:0]  gnt;
   logic [3:0]  done;
   logic        busy;
   logic [3:0]  cnt;

   int n_pass  = 0;
   int n_total = 0;

   count_sched #(
      .N_REQ (4),
      .CNT_W (4)
   ) u_dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .len  (len),
      .gnt  (gnt),
      .done (done),
      .busy (busy),
      .cnt  (cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      req = 4'b0000;
      len = 16'h0000;

      // reset state
      #12;
      chk("rst_gnt",  gnt,  0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cnt",  cnt,  0);

      // round robin, all len=0: owners 0,1,2,3,0, 3-cycle jobs + 1 idle
      @(negedge clk);
      rst = 1'b1;
      req = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         for (int c = 1; c <= 3; c++) begin
            step();
            chk("rr_gnt", gnt, 32'(1) << (j % 4));
            chk("rr_busy", busy, 1);
            if (c == 3) chk("rr_done", done, 32'(1) << (j % 4));
            else        chk("rr_nodone", done, 0);
         end
         if (j == 4) req = 4'b0000;
         step();
         chk("rr_idle_gnt", gnt, 0);
         chk("rr_idle_busy", busy, 0);
      end
      // ptr = 1 now

      // single job len[0]=5: 8 cycles of gnt, cnt 0..5, done in cycle 8
      len = 16'h0005;
      req = 4'b0001;
      for (int c = 1; c <= 8; c++) begin
         step();
         chk("sj_gnt", gnt, 4'b0001);
         if (c >= 2) chk("sj_cnt", cnt, (c == 8) ? 5 : c - 2);
         chk("sj_done", done, (c == 8) ? 4'b0001 : 4'b0000);
      end
      req = 4'b0000;
      step();
      chk("sj_idle_busy", busy, 0);
      chk("sj_idle_gnt", gnt, 0);

      // len[0] changed 5->2 mid-COUNT: job still counts to 5
      len = 16'h0005;
      req = 4'b0001;
      for (int c = 1; c <= 8; c++) begin
         step();
         if (c >= 2) chk("lc_cnt", cnt, (c == 8) ? 5 : c - 2);
         chk("lc_done", done, (c == 8) ? 4'b0001 : 4'b0000);
         if (c == 3) len = 16'h0002;
      end
      req = 4'b0000;
      step();
      chk("lc_idle_gnt", gnt, 0);
      // ptr = 1

      // len[2]=0: 3-cycle job
      len = 16'h0000;
      req = 4'b0100;
      for (int c = 1; c <= 3; c++) begin
         step();
         chk("z_gnt", gnt, 4'b0100);
         chk("z_done", done, (c == 3) ? 4'b0100 : 4'b0000);
      end
      req = 4'b0000;
      step();
      chk("z_idle", busy, 0);
      // ptr = 3

      // len[2]=15: 18-cycle job, cnt reaches 15 without wrapping
      len = 16'h0F00;
      req = 4'b0100;
      for (int c = 1; c <= 18; c++) begin
         step();
         chk("mx_gnt", gnt, 4'b0100);
         if (c >= 2) chk("mx_cnt", cnt, (c == 18) ? 15 : c - 2);
         chk("mx_done", done, (c == 18) ? 4'b0100 : 4'b0000);
      end
      req = 4'b0000;
      step();
      chk("mx_idle_gnt", gnt, 0);
      chk("mx_idle_cnt", cnt, 15);
      // ptr = 3

      // abort: owner 1 drops req at cnt=3; ptr -> 2 so req[2] beats req[0]
      len = 16'h0175;
      req = 4'b0010;
      step();
      chk("ab_load_gnt", gnt, 4'b0010);
      req = 4'b0111;
      for (int c = 2; c <= 5; c++) begin
         step();
         chk("ab_gnt", gnt, 4'b0010);
         chk("ab_cnt", cnt, c - 2);
      end
      req = 4'b0101;
      step();
      chk("ab_idle_gnt", gnt, 0);
      chk("ab_idle_busy", busy, 0);
      chk("ab_idle_done", done, 0);
      chk("ab_idle_cnt", cnt, 3);
      step();
      chk("ab_next_gnt", gnt, 4'b0100);
      step();
      chk("ab_next_cnt0", cnt, 0);
      step();
      chk("ab_next_cnt1", cnt, 1);
      step();
      chk("ab_next_done", done, 4'b0100);
      req = 4'b0001;
      step();
      chk("ab_next_idle", gnt, 0);
      // ptr = 3

      // async reset mid-COUNT, then req=1000 after release
      step();
      chk("ar_gnt", gnt, 4'b0001);
      step();
      step();
      chk("ar_cnt1", cnt, 1);
      #2;
      rst = 1'b0;
      #1;
      chk("ar_rst_gnt",  gnt,  0);
      chk("ar_rst_busy", busy, 0);
      chk("ar_rst_cnt",  cnt,  0);
      chk("ar_rst_done", done, 0);
      req = 4'b1000;
      step();
      chk("ar_held_gnt", gnt, 0);
      #2;
      rst = 1'b1;
      step();
      chk("ar_rel_gnt", gnt, 4'b1000);
      chk("ar_rel_busy", busy, 1);
      step();
      chk("ar_rel_cnt", cnt, 0);
      step();
      chk("ar_rel_done", done, 4'b1000);
      req = 4'b0000;
      step();
      chk("ar_end_gnt", gnt, 0);
      chk("ar_end_busy", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
